// File: rtl/ibpl_param_cardlet.sv
// ibpl_param_cardlet: parametrised N-channel interbackplane cardlet.
// Each channel is an input or an output, fixed at build time by DIR_MASK.
// Inputs get a 2-flop synchroniser and an optional debounce; outputs are
// registered and gated by their enable. Activity LEDs are stretched per channel.
// A registered direction-mismatch error keeps a sticky copy.
// Optional feature macro: IBPL_DEBOUNCE_EN (defined = debounce filter present).
module ibpl_param_cardlet #(
   parameter int unsigned     N_CH        = 6,
   parameter logic [N_CH-1:0] DIR_MASK    = 6'h20,
   parameter int unsigned     INT_W       = 8,
   parameter int unsigned     FILTER_LEN  = 4,
   parameter logic [15:0]     STRETCH_LEN = 16'd50000
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   diob_in,
   output logic [N_CH-1:0]   diob_out,
   output logic [N_CH-1:0]   diob_dir,
   input  logic [INT_W-1:0]  internal_out,
   output logic [INT_W-1:0]  internal_in,
   input  logic [INT_W-1:0]  input_enable,
   input  logic [INT_W-1:0]  output_enable,
   input  logic              err_clr,
   output logic [INT_W-1:0]  diob_led1,
   output logic [INT_W-1:0]  diob_led2,
   output logic              plugin_error,
   output logic              plugin_error_sticky
);

   localparam int unsigned      SW        = 16;
   localparam logic [N_CH-1:0]  IN_MASK_N = ~DIR_MASK;
   localparam logic [INT_W-1:0] OUT_MASK  = INT_W'(DIR_MASK);
   localparam logic [INT_W-1:0] IN_MASK   = INT_W'(IN_MASK_N);
`ifdef IBPL_DEBOUNCE_EN
   localparam logic [7:0]       FILT_LAST = 8'(FILTER_LEN - 1);
`endif

   logic [N_CH-1:0] out_vec;
   logic [N_CH-1:0] act_src;
   logic [N_CH-1:0] act_prev;
   logic [SW-1:0]   stretch [N_CH];
   logic            err_c;
   logic            unused_bits;

   assign diob_dir = DIR_MASK;
   assign diob_out = out_vec;

   // Bits that only matter for one direction, plus the filter length when
   // the debounce is compiled out.
   assign unused_bits = ^{internal_out, input_enable, output_enable, 8'(FILTER_LEN)};

   for (genvar i = 0; i < INT_W; i++) begin : g_ch
      if (i >= N_CH) begin : g_tie
         assign internal_in[i] = 1'b0;
         assign diob_led1[i]   = 1'b0;
         assign diob_led2[i]   = 1'b0;
      end else if (DIR_MASK[i]) begin : g_out
         logic q;

         // Output channel: register the enabled core value onto the pin
         always_ff @(posedge clk_sys or negedge rst_n) begin
            if (!rst_n) q <= 1'b0;
            else        q <= internal_out[i] & output_enable[i];
         end

         assign out_vec[i]     = q;
         assign act_src[i]     = q;
         assign internal_in[i] = 1'b0;
         assign diob_led1[i]   = output_enable[i];
         assign diob_led2[i]   = (stretch[i] != '0);
      end else begin : g_in
         logic sync1;
         logic sync2;
         logic filt;

         // Two-flop synchroniser on the raw backplane pin
         always_ff @(posedge clk_sys or negedge rst_n) begin
            if (!rst_n) begin
               sync1 <= 1'b0;
               sync2 <= 1'b0;
            end else begin
               sync1 <= diob_in[i];
               sync2 <= sync1;
            end
         end

`ifdef IBPL_DEBOUNCE_EN
         logic [7:0] cnt;

         // Debounce: accept a new level once it has differed for FILTER_LEN cycles
         always_ff @(posedge clk_sys or negedge rst_n) begin
            if (!rst_n) begin
               filt <= 1'b0;
               cnt  <= '0;
            end else if (!input_enable[i]) begin
               filt <= 1'b0;
               cnt  <= '0;
            end else if (sync2 == filt) begin
               cnt  <= '0;
            end else if (cnt == FILT_LAST) begin
               filt <= sync2;
               cnt  <= '0;
            end else begin
               cnt  <= cnt + 8'd1;
            end
         end
`else
         assign filt = sync2;
`endif

         assign internal_in[i] = filt & input_enable[i];
         assign out_vec[i]     = 1'b0;
         assign act_src[i]     = filt & input_enable[i];
         assign diob_led1[i]   = input_enable[i];
         assign diob_led2[i]   = (stretch[i] != '0);
      end
   end

   // Activity stretch: any change of the channel's visible value reloads the hold counter
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         act_prev <= '0;
         for (int unsigned i = 0; i < N_CH; i++) stretch[i] <= '0;
      end else begin
         act_prev <= act_src;
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (act_src[i] != act_prev[i])  stretch[i] <= STRETCH_LEN;
            else if (stretch[i] != '0)      stretch[i] <= stretch[i] - SW'(1);
         end
      end
   end

   // Mismatch: enable asserted for the direction the channel does not have
   assign err_c = |((IN_MASK  & output_enable & ~input_enable) |
                    (OUT_MASK & input_enable  & ~output_enable));

   // Registered error and its sticky copy; a live error blocks the clear
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         plugin_error        <= 1'b0;
         plugin_error_sticky <= 1'b0;
      end else begin
         plugin_error <= err_c;
         if (plugin_error)  plugin_error_sticky <= 1'b1;
         else if (err_clr)  plugin_error_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ibpl_param_cardlet.sv
// Bench for ibpl_param_cardlet: cycle model plus directed literal checks.
module tb_ibpl_param_cardlet;

   localparam int         FILT = 4;
   localparam int         S    = 20;
   localparam logic [5:0] MASK = 6'h20;
`ifdef IBPL_DEBOUNCE_EN
   localparam int         LAT  = 2 + FILT;
`else
   localparam int         LAT  = 2;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] din;
   logic [5:0] dout;
   logic [5:0] dir;
   logic [7:0] iout, iin, ie, oe, led1, led2;
   logic       err_clr, err, sticky;

   logic [7:0] din8, iout8, iin8, ie8, oe8;
   logic [7:0] unused8_dout, unused8_dir, unused8_led1, unused8_led2;
   logic       unused8_err, unused8_sticky;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ibpl_param_cardlet #(.N_CH(6), .DIR_MASK(6'h20), .INT_W(8),
                        .FILTER_LEN(FILT), .STRETCH_LEN(16'(S))) u_dut (
      .clk_sys(clk), .rst_n(rst_n), .diob_in(din), .diob_out(dout), .diob_dir(dir),
      .internal_out(iout), .internal_in(iin), .input_enable(ie), .output_enable(oe),
      .err_clr(err_clr), .diob_led1(led1), .diob_led2(led2),
      .plugin_error(err), .plugin_error_sticky(sticky));

   ibpl_param_cardlet #(.N_CH(8), .DIR_MASK(8'h0F), .INT_W(8),
                        .FILTER_LEN(FILT), .STRETCH_LEN(16'(S))) u_dut8 (
      .clk_sys(clk), .rst_n(rst_n), .diob_in(din8), .diob_out(unused8_dout),
      .diob_dir(unused8_dir), .internal_out(iout8), .internal_in(iin8),
      .input_enable(ie8), .output_enable(oe8), .err_clr(1'b0),
      .diob_led1(unused8_led1), .diob_led2(unused8_led2),
      .plugin_error(unused8_err), .plugin_error_sticky(unused8_sticky));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   logic [5:0] m_s1 = '0, m_s2 = '0, m_filt = '0, m_dout = '0, m_prev = '0;
   int         m_run [6];
   bit         m_evt_v [6];
   int         m_evt [6];
   int         ecount = 0;
   logic       m_err = 1'b0, m_sticky = 1'b0;

   function automatic logic [7:0] exp_internal();
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         if (!MASK[i]) begin
`ifdef IBPL_DEBOUNCE_EN
            r[i] = m_filt[i] & ie[i];
`else
            r[i] = m_s2[i] & ie[i];
`endif
         end
      end
      return r;
   endfunction

   function automatic logic exp_err_cond();
      logic e;
      e = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (MASK[i]) e = e | (ie[i] & ~oe[i]);
         else         e = e | (oe[i] & ~ie[i]);
      end
      return e;
   endfunction

   function automatic logic [7:0] exp_led1();
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) r[i] = MASK[i] ? oe[i] : ie[i];
      return r;
   endfunction

   function automatic logic [7:0] exp_led2();
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) r[i] = m_evt_v[i] && ((ecount - m_evt[i]) < S);
      return r;
   endfunction

   // Model advance on every clock edge, from the inputs as they stood before the edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_filt = '0; m_dout = '0; m_prev = '0;
         m_err = 1'b0; m_sticky = 1'b0;
         for (int i = 0; i < 6; i++) begin
            m_run[i] = 0; m_evt_v[i] = 1'b0; m_evt[i] = 0;
         end
      end else begin
         logic [5:0] act;
         act = exp_internal()[5:0] | m_dout;
         for (int i = 0; i < 6; i++) begin
            if (act[i] != m_prev[i]) begin
               m_evt_v[i] = 1'b1;
               m_evt[i]   = ecount + 1;
            end
         end
         m_prev = act;
         if (m_err)        m_sticky = 1'b1;
         else if (err_clr) m_sticky = 1'b0;
         m_err = exp_err_cond();
         for (int i = 0; i < 6; i++) begin
            if (MASK[i]) m_dout[i] = iout[i] & oe[i];
            else if (!ie[i]) begin
               m_filt[i] = 1'b0; m_run[i] = 0;
            end else if (m_s2[i] == m_filt[i]) begin
               m_run[i] = 0;
            end else begin
               m_run[i]++;
               if (m_run[i] == FILT) begin
                  m_filt[i] = m_s2[i]; m_run[i] = 0;
               end
            end
         end
         m_s2 = m_s1;
         m_s1 = din & ~MASK;
         ecount++;
      end
   end

   // Per-cycle comparison against the model, mid-cycle
   always @(negedge clk) begin
      check("model_internal_in", 32'(iin), 32'(exp_internal()));
      check("model_diob_out", 32'(dout), 32'(m_dout));
      check("model_diob_led2", 32'(led2), 32'(exp_led2()));
      check("model_led1", 32'(led1), 32'(exp_led1()));
      check("model_plugin_error", 32'(err), 32'(m_err));
      check("model_sticky", 32'(sticky), 32'(m_sticky));
      check("model_diob_dir", 32'(dir), 32'(MASK));
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst_n = 1'b1; din = '0; ie = '0; oe = '0; iout = '0; err_clr = 1'b0;
      din8 = '0; ie8 = '0; oe8 = '0; iout8 = '0;
      #1 rst_n = 1'b0;
      #2;
      check("rst_internal_in", 32'(iin), 32'h0);
      check("rst_diob_out", 32'(dout), 32'h0);
      check("rst_led2", 32'(led2), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_sticky", 32'(sticky), 32'h0);
      check("rst_dir", 32'(dir), 32'h20);
      repeat (2) tick();
      rst_n = 1'b1;

      // Input path latency and LED stretch on channel 0
      ie = 8'h1F; oe = 8'h20;
      tick();
      check("led1_enables", 32'(led1), 32'h3F);
      din[0] = 1'b1;
      repeat (LAT - 1) tick();
      check("in0_before_latency", 32'(iin), 32'h00);
      tick();
      check("in0_at_latency", 32'(iin), 32'h01);
      check("led2_not_yet", 32'(led2), 32'h00);
      tick();
      check("led2_rise", 32'(led2), 32'h01);
      repeat (S - 1) tick();
      check("led2_last_high", 32'(led2), 32'h01);
      tick();
      check("led2_expired", 32'(led2), 32'h00);

      // Wide instance, channel 7 as input
      ie8 = 8'hF0;
      tick();
      din8[7] = 1'b1;
      repeat (LAT - 1) tick();
      check("dut8_in7_before", 32'(iin8), 32'h00);
      tick();
      check("dut8_in7_at", 32'(iin8), 32'h80);

      // Three-cycle glitch on channel 2
      din[2] = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         tick();
         if (t == 3) din[2] = 1'b0;
`ifdef IBPL_DEBOUNCE_EN
         check("glitch_in2", 32'(iin[2]), 32'h0);
         check("glitch_led2", 32'(led2[2]), 32'h0);
`else
         check("glitch_in2", 32'(iin[2]), 32'((t >= 2) && (t <= 4)));
         check("glitch_led2", 32'(led2[2]), 32'(t >= 3));
`endif
      end

      // Output path and LED retrigger on channel 5
      iout = 8'h20;
      tick();
      check("out5_set", 32'(dout), 32'h20);
      tick();
      check("out5_led_rise", 32'(led2[5]), 32'h1);
      repeat (2) tick();
      oe = 8'h00;
      tick();
      check("out5_cleared", 32'(dout), 32'h00);
      check("led1_out_disabled", 32'(led1), 32'h1F);
      tick();
      check("out5_led_retrig", 32'(led2[5]), 32'h1);
      repeat (S - 1) tick();
      check("out5_led_hold", 32'(led2[5]), 32'h1);
      tick();
      check("out5_led_expired", 32'(led2[5]), 32'h0);

      // Direction mismatch and sticky error
      ie = 8'h3F; oe = 8'h00;
      tick();
      check("err_set", 32'(err), 32'h1);
      check("sticky_lag", 32'(sticky), 32'h0);
      tick();
      check("sticky_set", 32'(sticky), 32'h1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("sticky_clr_blocked", 32'(sticky), 32'h1);
      ie = 8'h1F; oe = 8'h20;
      tick();
      check("err_cleared", 32'(err), 32'h0);
      check("sticky_held", 32'(sticky), 32'h1);
      tick();
      check("sticky_still", 32'(sticky), 32'h1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("sticky_cleared", 32'(sticky), 32'h0);

      // Reset mid-debounce and mid-stretch
      din = 6'h03;
      repeat (3) tick();
      check("pre_reset_led5", 32'(led2[5]), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_internal_in", 32'(iin), 32'h0);
      check("mid_rst_diob_out", 32'(dout), 32'h0);
      check("mid_rst_led2", 32'(led2), 32'h0);
      check("mid_rst_err", 32'(err), 32'h0);
      check("mid_rst_sticky", 32'(sticky), 32'h0);
      check("mid_rst_dut8", 32'(iin8), 32'h0);
      tick();
      rst_n = 1'b1;
      repeat (LAT - 1) tick();
      check("post_rst_before", 32'(iin), 32'h00);
      tick();
      check("post_rst_at", 32'(iin), 32'h03);

      repeat (5) tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
